// File: rtl/id_stage_reg_pkg.sv
// Shared definitions for the ID->EXE pipeline register: ALU command
// encodings, immediate field widths and the cleared control word.
package id_stage_reg_pkg;

  // ALU commands produced by the decoder; NOP is the cleared/bubble value
  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W    = 24;

  // Decoded control word carried from decode into execute
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

  // Value the control word takes on reset and flush
  localparam ctrl_t CTRL_RESET = '{
    exe_cmd:   EXE_NOP,
    mem_read:  1'b0,
    mem_write: 1'b0,
    wb_en:     1'b0,
    b:         1'b0,
    s:         1'b0
  };

endpackage

// File: rtl/id_stage_reg_sat_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
// Holds at its maximum value instead of wrapping; only reset clears it.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_stage_reg.sv
// ID->EXE pipeline register with flush (taken branch), freeze (stall)
// and saturating bubble/stall counters.
// Optional feature macro: ID_STAGE_REG_FWD_EN adds the src1/src2 register
// numbers used by the forwarding unit in EXE.
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [SHIFT_OP_W-1:0] shift_operand_in,
  input  logic [IMM24_W-1:0]    signed_imm24_in,
  input  logic [3:0]            dest_in,
  input  logic                  carry_in,
`ifdef ID_STAGE_REG_FWD_EN
  input  logic [3:0]            src1_in,
  input  logic [3:0]            src2_in,
  output logic [3:0]            src1,
  output logic [3:0]            src2,
`endif
  output logic [DATA_W-1:0]     pc,
  output logic [3:0]            exe_cmd,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_en,
  output logic                  b,
  output logic                  s,
  output logic [DATA_W-1:0]     val_rn,
  output logic [DATA_W-1:0]     val_rm,
  output logic                  imm,
  output logic [SHIFT_OP_W-1:0] shift_operand,
  output logic [IMM24_W-1:0]    signed_imm24,
  output logic [3:0]            dest,
  output logic                  carry,
  output logic                  valid,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  ctrl_t ctrl_q;
  ctrl_t ctrl_in;

  // A flush wins over a simultaneous freeze, so a stall is only counted
  // when no bubble is being inserted in the same cycle.
  logic bubble_inc;
  logic stall_inc;

  assign bubble_inc = flush;
  assign stall_inc  = freeze & ~flush;

  assign ctrl_in = '{
    exe_cmd:   exe_cmd_in,
    mem_read:  mem_read_in,
    mem_write: mem_write_in,
    wb_en:     wb_en_in,
    b:         b_in,
    s:         s_in
  };

  assign exe_cmd   = ctrl_q.exe_cmd;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign wb_en     = ctrl_q.wb_en;
  assign b         = ctrl_q.b;
  assign s         = ctrl_q.s;

  // Field register: clear on reset/flush, hold on freeze, otherwise load
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      ctrl_q        <= CTRL_RESET;
      pc            <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm24  <= '0;
      dest          <= '0;
      carry         <= 1'b0;
      valid         <= 1'b0;
`ifdef ID_STAGE_REG_FWD_EN
      src1          <= '0;
      src2          <= '0;
`endif
    end else if (!freeze) begin
      ctrl_q        <= ctrl_in;
      pc            <= pc_in;
      val_rn        <= val_rn_in;
      val_rm        <= val_rm_in;
      imm           <= imm_in;
      shift_operand <= shift_operand_in;
      signed_imm24  <= signed_imm24_in;
      dest          <= dest_in;
      carry         <= carry_in;
      valid         <= 1'b1;
`ifdef ID_STAGE_REG_FWD_EN
      src1          <= src1_in;
      src2          <= src2_in;
`endif
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed testbench for id_stage_reg. A 16-bit-counter instance carries
// the main checks; a 4-bit-counter instance sharing the same inputs
// exercises counter saturation.
module tb_id_stage_reg;

  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        freeze;
  logic [31:0] pc_in;
  logic [3:0]  exe_cmd_in;
  logic        mem_read_in, mem_write_in, wb_en_in, b_in, s_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic [3:0]  dest_in;
  logic        carry_in;

  logic [31:0] pc;
  logic [3:0]  exe_cmd;
  logic        mem_read, mem_write, wb_en, b, s;
  logic [31:0] val_rn, val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm24;
  logic [3:0]  dest;
  logic        carry;
  logic        valid;
  logic [15:0] bubble_cnt, stall_cnt;

  logic [31:0] s_pc;
  logic [3:0]  s_exe_cmd;
  logic        s_mem_read, s_mem_write, s_wb_en, s_b, s_s;
  logic [31:0] s_val_rn, s_val_rm;
  logic        s_imm;
  logic [11:0] s_shift_operand;
  logic [23:0] s_signed_imm24;
  logic [3:0]  s_dest;
  logic        s_carry;
  logic        s_valid;
  logic [3:0]  s_bubble_cnt, s_stall_cnt;

`ifdef ID_STAGE_REG_FWD_EN
  logic [3:0] src1_in, src2_in, src1, src2, s_src1, s_src2;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  id_stage_reg #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .exe_cmd_in(exe_cmd_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .carry_in(carry_in),
`ifdef ID_STAGE_REG_FWD_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1(src1), .src2(src2),
`endif
    .pc(pc), .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .wb_en(wb_en), .b(b), .s(s), .val_rn(val_rn), .val_rm(val_rm),
    .imm(imm), .shift_operand(shift_operand), .signed_imm24(signed_imm24),
    .dest(dest), .carry(carry), .valid(valid),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  id_stage_reg #(.DATA_W(DATA_W), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .exe_cmd_in(exe_cmd_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .carry_in(carry_in),
`ifdef ID_STAGE_REG_FWD_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1(s_src1), .src2(s_src2),
`endif
    .pc(s_pc), .exe_cmd(s_exe_cmd), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .wb_en(s_wb_en), .b(s_b), .s(s_s),
    .val_rn(s_val_rn), .val_rm(s_val_rm), .imm(s_imm),
    .shift_operand(s_shift_operand), .signed_imm24(s_signed_imm24),
    .dest(s_dest), .carry(s_carry), .valid(s_valid),
    .bubble_cnt(s_bubble_cnt), .stall_cnt(s_stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] p, input logic [3:0] cmd,
                               input logic mr, input logic mw, input logic wb,
                               input logic br, input logic st,
                               input logic [31:0] rn, input logic [31:0] rm,
                               input logic im, input logic [11:0] sh,
                               input logic [23:0] off, input logic [3:0] d,
                               input logic c);
    pc_in = p;  exe_cmd_in = cmd;
    mem_read_in = mr;  mem_write_in = mw;  wb_en_in = wb;
    b_in = br;  s_in = st;
    val_rn_in = rn;  val_rm_in = rm;  imm_in = im;
    shift_operand_in = sh;  signed_imm24_in = off;
    dest_in = d;  carry_in = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;  flush = 1'b0;  freeze = 1'b0;
`ifdef ID_STAGE_REG_FWD_EN
    src1_in = 4'd0;  src2_in = 4'd0;
`endif
    applyStimulus(32'h10, 4'b0010, 0, 0, 1, 0, 1, 32'd5, 32'd7, 0,
                  12'h0, 24'h0, 4'd3, 1'b1);
    tick();
    tick();

    // Reset state: inputs are live but nothing is captured while rst is high
    checkOutput("rst_valid", 64'(valid), 64'd0);
    checkOutput("rst_exe_cmd", 64'(exe_cmd), 64'd0);
    checkOutput("rst_pc", 64'(pc), 64'd0);
    checkOutput("rst_bubble", 64'(bubble_cnt), 64'd0);
    checkOutput("rst_stall", 64'(stall_cnt), 64'd0);

    // First load after reset release: ADD r3 = 5 + 7, S set
    rst = 1'b0;
    tick();
    checkOutput("load_exe_cmd", 64'(exe_cmd), 64'h2);
    checkOutput("load_wb_en", 64'(wb_en), 64'd1);
    checkOutput("load_s", 64'(s), 64'd1);
    checkOutput("load_dest", 64'(dest), 64'd3);
    checkOutput("load_valid", 64'(valid), 64'd1);
    checkOutput("load_val_rn", 64'(val_rn), 64'd5);
    checkOutput("load_val_rm", 64'(val_rm), 64'd7);
    checkOutput("load_pc", 64'(pc), 64'h10);
    checkOutput("load_carry", 64'(carry), 64'd1);
    checkOutput("load_mem_write", 64'(mem_write), 64'd0);

    // Freeze 3 cycles while an STR waits at the inputs
    freeze = 1'b1;
    applyStimulus(32'h14, 4'b0010, 0, 1, 0, 0, 0, 32'd8, 32'd9, 1,
                  12'hABC, 24'h123456, 4'd4, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("frz_exe_cmd", 64'(exe_cmd), 64'h2);
    checkOutput("frz_wb_en", 64'(wb_en), 64'd1);
    checkOutput("frz_mem_write", 64'(mem_write), 64'd0);
    checkOutput("frz_pc", 64'(pc), 64'h10);
    checkOutput("frz_dest", 64'(dest), 64'd3);
    checkOutput("frz_valid", 64'(valid), 64'd1);
    checkOutput("frz_stall", 64'(stall_cnt), 64'd3);
    checkOutput("frz_bubble", 64'(bubble_cnt), 64'd0);

    // Flush and freeze together: flush wins, only bubble counter moves
    flush = 1'b1;
    tick();
    checkOutput("fl_exe_cmd", 64'(exe_cmd), 64'd0);
    checkOutput("fl_valid", 64'(valid), 64'd0);
    checkOutput("fl_pc", 64'(pc), 64'd0);
    checkOutput("fl_val_rn", 64'(val_rn), 64'd0);
    checkOutput("fl_wb_en", 64'(wb_en), 64'd0);
    checkOutput("fl_bubble", 64'(bubble_cnt), 64'd1);
    checkOutput("fl_stall", 64'(stall_cnt), 64'd3);
    checkOutput("fl_small_bubble", 64'(s_bubble_cnt), 64'd1);
    checkOutput("fl_small_stall", 64'(s_stall_cnt), 64'd3);

    // Release: the held STR now loads
    flush = 1'b0;
    freeze = 1'b0;
    tick();
    checkOutput("str_mem_write", 64'(mem_write), 64'd1);
    checkOutput("str_wb_en", 64'(wb_en), 64'd0);
    checkOutput("str_pc", 64'(pc), 64'h14);
    checkOutput("str_val_rm", 64'(val_rm), 64'd9);
    checkOutput("str_imm", 64'(imm), 64'd1);
    checkOutput("str_shift_op", 64'(shift_operand), 64'hABC);
    checkOutput("str_imm24", 64'(signed_imm24), 64'h123456);
    checkOutput("str_dest", 64'(dest), 64'd4);
    checkOutput("str_valid", 64'(valid), 64'd1);

    // Incoming decoded bubble still loads with valid set
    applyStimulus(32'h18, 4'b0000, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0,
                  12'h0, 24'h0, 4'd0, 1'b0);
    tick();
    checkOutput("dbub_valid", 64'(valid), 64'd1);
    checkOutput("dbub_pc", 64'(pc), 64'h18);
    checkOutput("dbub_mem_write", 64'(mem_write), 64'd0);

    // Load ADD at pc 0x10, then assert reset between clock edges
    applyStimulus(32'h10, 4'b0010, 0, 0, 1, 0, 0, 32'd1, 32'd2, 0,
                  12'h0, 24'h0, 4'd1, 1'b0);
    tick();
    checkOutput("pre_rst_pc", 64'(pc), 64'h10);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_exe_cmd", 64'(exe_cmd), 64'd0);
    checkOutput("arst_wb_en", 64'(wb_en), 64'd0);
    checkOutput("arst_pc", 64'(pc), 64'd0);
    checkOutput("arst_valid", 64'(valid), 64'd0);
    checkOutput("arst_bubble", 64'(bubble_cnt), 64'd0);
    checkOutput("arst_stall", 64'(stall_cnt), 64'd0);

    // Reset held over an edge with flush and freeze: nothing counts
    flush = 1'b1;
    freeze = 1'b1;
    tick();
    checkOutput("rstfl_bubble", 64'(bubble_cnt), 64'd0);
    checkOutput("rstfl_stall", 64'(stall_cnt), 64'd0);
    checkOutput("rstfl_valid", 64'(valid), 64'd0);

    // 20 flush cycles: 4-bit counter saturates at 15, 16-bit reaches 20
    rst = 1'b0;
    freeze = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_small_bubble", 64'(s_bubble_cnt), 64'd15);
    checkOutput("sat_bubble", 64'(bubble_cnt), 64'd20);
    checkOutput("sat_small_stall", 64'(s_stall_cnt), 64'd0);

    // Freeze 2 cycles after saturation: bubble counter sticks
    flush = 1'b0;
    freeze = 1'b1;
    tick();
    tick();
    checkOutput("post_small_bubble", 64'(s_bubble_cnt), 64'd15);
    checkOutput("post_small_stall", 64'(s_stall_cnt), 64'd2);
    checkOutput("post_stall", 64'(stall_cnt), 64'd2);
    checkOutput("post_frz_valid", 64'(valid), 64'd0);

`ifdef ID_STAGE_REG_FWD_EN
    // Forwarding register numbers follow the same load/flush rules
    freeze = 1'b0;
    src1_in = 4'd4;
    src2_in = 4'd9;
    tick();
    checkOutput("fwd_src1", 64'(src1), 64'd4);
    checkOutput("fwd_src2", 64'(src2), 64'd9);
    flush = 1'b1;
    tick();
    checkOutput("fwd_fl_src1", 64'(src1), 64'd0);
    checkOutput("fwd_fl_src2", 64'(src2), 64'd0);
    flush = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
